// File: rtl/axil_reg_if_arb.sv
// rtl/axil_reg_if_arb.sv - round-robin arbiter merging rd/wr register requests onto one register port
module axil_reg_if_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_reg_rd_addr,
   input  logic                  s_reg_rd_en,
   output logic [DATA_WIDTH-1:0] s_reg_rd_data,
   output logic                  s_reg_rd_wait,
   output logic                  s_reg_rd_ack,
   input  logic [ADDR_WIDTH-1:0] s_reg_wr_addr,
   input  logic [DATA_WIDTH-1:0] s_reg_wr_data,
   input  logic [STRB_WIDTH-1:0] s_reg_wr_strb,
   input  logic                  s_reg_wr_en,
   output logic                  s_reg_wr_wait,
   output logic                  s_reg_wr_ack,
   output logic [ADDR_WIDTH-1:0] m_reg_addr,
   output logic [DATA_WIDTH-1:0] m_reg_wr_data,
   output logic [STRB_WIDTH-1:0] m_reg_wr_strb,
   output logic                  m_reg_wr_en,
   output logic                  m_reg_rd_en,
   input  logic [DATA_WIDTH-1:0] m_reg_rd_data,
   input  logic                  m_reg_wait,
   input  logic                  m_reg_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   localparam logic GNT_RD = 1'b0;
   localparam logic GNT_WR = 1'b1;

   localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;

   logic req_en;
   logic cnt_zero;
   logic done;
   logic forced;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GNT_WR;
         cnt_q        <= CNT_INIT;
         addr_q       <= '0;
         wr_data_q    <= '0;
         wr_strb_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wr_data_q    <= wr_data_d;
         wr_strb_q    <= wr_strb_d;
      end
   end

   // A completion only counts while the granted requester still holds its en.
   always_comb begin
      req_en   = (state_q == ST_RD) ? s_reg_rd_en : s_reg_wr_en;
      cnt_zero = (cnt_q == '0);
      forced   = cnt_zero && !m_reg_ack;
      done     = (state_q != ST_IDLE) && req_en && (m_reg_ack || cnt_zero);
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wr_data_d    = wr_data_q;
      wr_strb_d    = wr_strb_q;
      case (state_q)
         ST_IDLE: begin
            if (s_reg_rd_en && (!s_reg_wr_en || last_grant_q == GNT_WR)) begin
               state_d      = ST_RD;
               last_grant_d = GNT_RD;
               cnt_d        = CNT_INIT;
               addr_d       = s_reg_rd_addr;
            end else if (s_reg_wr_en) begin
               state_d      = ST_WR;
               last_grant_d = GNT_WR;
               cnt_d        = CNT_INIT;
               addr_d       = s_reg_wr_addr;
               wr_data_d    = s_reg_wr_data;
               wr_strb_d    = s_reg_wr_strb;
            end
         end
         ST_RD, ST_WR: begin
            // Abort and completion both release the port; no decrement past zero since zero completes.
            if (!req_en || done) begin
               state_d = ST_IDLE;
            end else if (!m_reg_wait) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m_reg_rd_en   = (state_q == ST_RD);
   assign m_reg_wr_en   = (state_q == ST_WR);
   assign m_reg_addr    = addr_q;
   assign m_reg_wr_data = wr_data_q;
   assign m_reg_wr_strb = wr_strb_q;

   assign s_reg_rd_wait = (state_q == ST_RD) ? m_reg_wait : 1'b1;
   assign s_reg_wr_wait = (state_q == ST_WR) ? m_reg_wait : 1'b1;
   assign s_reg_rd_ack  = (state_q == ST_RD) && done;
   assign s_reg_wr_ack  = (state_q == ST_WR) && done;
   assign s_reg_rd_data = ((state_q == ST_RD) && !forced) ? m_reg_rd_data : '0;

endmodule

// File: tb/tb_axil_reg_if_arb.sv
// tb/tb_axil_reg_if_arb.sv - table-driven cycle vectors for axil_reg_if_arb
module tb_axil_reg_if_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_reg_rd_addr = '0;
   logic        s_reg_rd_en = 1'b0;
   logic [31:0] s_reg_rd_data;
   logic        s_reg_rd_wait, s_reg_rd_ack;
   logic [31:0] s_reg_wr_addr = '0;
   logic [31:0] s_reg_wr_data = '0;
   logic [3:0]  s_reg_wr_strb = '0;
   logic        s_reg_wr_en = 1'b0;
   logic        s_reg_wr_wait, s_reg_wr_ack;
   logic [31:0] m_reg_addr, m_reg_wr_data;
   logic [3:0]  m_reg_wr_strb;
   logic        m_reg_wr_en, m_reg_rd_en;
   logic [31:0] m_reg_rd_data = '0;
   logic        m_reg_wait = 1'b0;
   logic        m_reg_ack = 1'b0;

   always #5 clk = ~clk;

   axil_reg_if_arb #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .TIMEOUT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_reg_rd_addr(s_reg_rd_addr),
      .s_reg_rd_en(s_reg_rd_en),
      .s_reg_rd_data(s_reg_rd_data),
      .s_reg_rd_wait(s_reg_rd_wait),
      .s_reg_rd_ack(s_reg_rd_ack),
      .s_reg_wr_addr(s_reg_wr_addr),
      .s_reg_wr_data(s_reg_wr_data),
      .s_reg_wr_strb(s_reg_wr_strb),
      .s_reg_wr_en(s_reg_wr_en),
      .s_reg_wr_wait(s_reg_wr_wait),
      .s_reg_wr_ack(s_reg_wr_ack),
      .m_reg_addr(m_reg_addr),
      .m_reg_wr_data(m_reg_wr_data),
      .m_reg_wr_strb(m_reg_wr_strb),
      .m_reg_wr_en(m_reg_wr_en),
      .m_reg_rd_en(m_reg_rd_en),
      .m_reg_rd_data(m_reg_rd_data),
      .m_reg_wait(m_reg_wait),
      .m_reg_ack(m_reg_ack)
   );

   // flags = {m_reg_rd_en, m_reg_wr_en, s_reg_rd_ack, s_reg_rd_wait, s_reg_wr_ack, s_reg_wr_wait}
   localparam logic [5:0] F_IDLE   = 6'b000101;
   localparam logic [5:0] F_RD     = 6'b100001;
   localparam logic [5:0] F_RD_ACK = 6'b101001;
   localparam logic [5:0] F_WR     = 6'b010100;
   localparam logic [5:0] F_WR_ACK = 6'b010110;
   localparam logic [5:0] F_WR_WT  = 6'b010101;

   typedef struct {
      logic        rst;
      logic        rd_en;
      logic [31:0] rd_addr;
      logic        wr_en;
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
      logic [3:0]  wr_strb;
      logic        m_wait;
      logic        m_ack;
      logic [31:0] m_rdata;
      logic [5:0]  flags;
      logic [31:0] exp_rdata;
      logic        chk_bus;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_strb;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   function automatic vec_t v(input logic r, input logic re, input logic [31:0] ra,
                              input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws, input logic mw, input logic mk,
                              input logic [31:0] md, input logic [5:0] f, input logic [31:0] erd,
                              input logic cb, input logic [31:0] ea, input logic [31:0] ewd,
                              input logic [3:0] ews);
      vec_t t;
      t.rst = r; t.rd_en = re; t.rd_addr = ra; t.wr_en = we; t.wr_addr = wa;
      t.wr_data = wd; t.wr_strb = ws; t.m_wait = mw; t.m_ack = mk; t.m_rdata = md;
      t.flags = f; t.exp_rdata = erd; t.chk_bus = cb; t.exp_addr = ea;
      t.exp_wdata = ewd; t.exp_strb = ews;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      // reset state
      vecs.push_back(v(1,0,0,0,0,0,0,0,0,0, F_IDLE,0, 1,0,0,0));
      // tie after reset: read first, then pending write
      vecs.push_back(v(0,1,32'h4,1,32'h8,32'h12345678,4'hF,0,0,0, F_IDLE,0, 1,0,0,0));
      vecs.push_back(v(0,1,32'h4,1,32'h8,32'h12345678,4'hF,0,1,32'hCAFE0001, F_RD_ACK,32'hCAFE0001, 1,32'h4,0,0));
      vecs.push_back(v(0,0,0,1,32'h8,32'h12345678,4'hF,0,0,0, F_IDLE,0, 1,32'h4,0,0));
      vecs.push_back(v(0,0,0,1,32'h8,32'h12345678,4'hF,0,1,0, F_WR_ACK,0, 1,32'h8,32'h12345678,4'hF));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      // single read, ack on first m_reg_rd_en cycle
      vecs.push_back(v(0,1,32'h10,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      vecs.push_back(v(0,1,32'h10,0,0,0,0,0,1,32'hDEADBEEF, F_RD_ACK,32'hDEADBEEF, 1,32'h10,32'h12345678,4'hF));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      // tie with last grant = RD: write wins
      vecs.push_back(v(0,1,32'h20,1,32'h24,32'hA5A5A5A5,4'h3,0,0,0, F_IDLE,0, 0,0,0,0));
      vecs.push_back(v(0,1,32'h20,1,32'h24,32'hA5A5A5A5,4'h3,0,1,0, F_WR_ACK,0, 1,32'h24,32'hA5A5A5A5,4'h3));
      vecs.push_back(v(0,1,32'h20,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      vecs.push_back(v(0,1,32'h20,0,0,0,0,0,1,32'h11, F_RD_ACK,32'h11, 1,32'h20,32'hA5A5A5A5,4'h3));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      // bank never acks: forced completion on 4th m_reg_rd_en cycle with zero data
      vecs.push_back(v(0,1,32'h30,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(v(0,1,32'h30,0,0,0,0,0,0,32'hFFFFFFFF, F_RD,32'hFFFFFFFF, 1,32'h30,32'hA5A5A5A5,4'h3));
      vecs.push_back(v(0,1,32'h30,0,0,0,0,0,0,32'hFFFFFFFF, F_RD_ACK,0, 1,32'h30,32'hA5A5A5A5,4'h3));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,32'hFFFFFFFF, F_IDLE,0, 0,0,0,0));
      // long bank wait freezes the timeout, single real ack
      vecs.push_back(v(0,0,0,1,32'h40,32'h0BADF00D,4'hC,0,0,0, F_IDLE,0, 0,0,0,0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(v(0,0,0,1,32'h40,32'h0BADF00D,4'hC,1,0,0, F_WR_WT,0, 1,32'h40,32'h0BADF00D,4'hC));
      vecs.push_back(v(0,0,0,1,32'h40,32'h0BADF00D,4'hC,0,1,0, F_WR_ACK,0, 1,32'h40,32'h0BADF00D,4'hC));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      // real ack coinciding with count==0 returns real data
      vecs.push_back(v(0,1,32'h44,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(v(0,1,32'h44,0,0,0,0,0,0,32'h77, F_RD,32'h77, 1,32'h44,32'h0BADF00D,4'hC));
      vecs.push_back(v(0,1,32'h44,0,0,0,0,0,1,32'h77, F_RD_ACK,32'h77, 1,32'h44,32'h0BADF00D,4'hC));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      // reader aborts before ack; pending write granted next
      vecs.push_back(v(0,1,32'h50,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));
      vecs.push_back(v(0,1,32'h50,1,32'h54,32'h55,4'h1,0,0,0, F_RD,0, 1,32'h50,32'h0BADF00D,4'hC));
      vecs.push_back(v(0,0,0,1,32'h54,32'h55,4'h1,0,0,0, F_RD,0, 1,32'h50,32'h0BADF00D,4'hC));
      vecs.push_back(v(0,0,0,1,32'h54,32'h55,4'h1,0,0,0, F_IDLE,0, 1,32'h50,32'h0BADF00D,4'hC));
      vecs.push_back(v(0,0,0,1,32'h54,32'h55,4'h1,0,1,0, F_WR_ACK,0, 1,32'h54,32'h55,4'h1));
      // bank ack while idle is ignored
      vecs.push_back(v(0,0,0,0,0,0,0,0,1,32'h99, F_IDLE,0, 0,0,0,0));
      // reset mid-write, then tie goes to read
      vecs.push_back(v(0,0,0,1,32'h60,32'h66,4'hF,0,0,0, F_IDLE,0, 0,0,0,0));
      vecs.push_back(v(0,0,0,1,32'h60,32'h66,4'hF,0,0,0, F_WR,0, 1,32'h60,32'h66,4'hF));
      vecs.push_back(v(1,0,0,1,32'h60,32'h66,4'hF,0,0,0, F_IDLE,0, 1,0,0,0));
      vecs.push_back(v(0,1,32'h70,1,32'h74,32'h7,4'h1,0,0,0, F_IDLE,0, 1,0,0,0));
      vecs.push_back(v(0,1,32'h70,1,32'h74,32'h7,4'h1,0,1,32'h70, F_RD_ACK,32'h70, 1,32'h70,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, F_IDLE,0, 0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst           = vecs[i].rst;
         s_reg_rd_en   = vecs[i].rd_en;
         s_reg_rd_addr = vecs[i].rd_addr;
         s_reg_wr_en   = vecs[i].wr_en;
         s_reg_wr_addr = vecs[i].wr_addr;
         s_reg_wr_data = vecs[i].wr_data;
         s_reg_wr_strb = vecs[i].wr_strb;
         m_reg_wait    = vecs[i].m_wait;
         m_reg_ack     = vecs[i].m_ack;
         m_reg_rd_data = vecs[i].m_rdata;
         #1;
         check("flags", i,
               68'({m_reg_rd_en, m_reg_wr_en, s_reg_rd_ack, s_reg_rd_wait, s_reg_wr_ack, s_reg_wr_wait}),
               68'(vecs[i].flags));
         check("rd_data", i, 68'(s_reg_rd_data), 68'(vecs[i].exp_rdata));
         if (vecs[i].chk_bus)
            check("bus", i, {m_reg_addr, m_reg_wr_data, m_reg_wr_strb},
                  {vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_strb});
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
